// File: rtl/ex_issue_if.sv
// ex_issue_if: bundles the ID-slot inputs, the EX/MEM and MEM/WB forwarding
// sources, the pipeline controls and the registered ID/EX outputs of
// ex_issue_stage.
//   master: decode/fetch side (drives ID fields, forwarding, stall/flush;
//           observes hazard_stall and the EX register outputs)
//   slave : the issue stage itself
interface ex_issue_if #(
  parameter int XLEN = 32
);
  // decode slot
  logic            id_valid;
  logic [1:0]      id_cls;
  logic            id_is_load;
  logic [2:0]      id_funct3;
  logic            id_funct7b5;
  logic            id_use_pc;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [XLEN-1:0] id_pc;
  // forwarding sources
  logic            mem_wen;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            wb_wen;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  // pipeline control
  logic            stall;
  logic            flush;
  logic            hazard_stall;
  // ID/EX register outputs
  logic            ex_valid;
  logic [3:0]      ex_alu_op;
  logic [XLEN-1:0] ex_alu_a;
  logic [XLEN-1:0] ex_alu_b;
  logic [XLEN-1:0] ex_store_data;
  logic [4:0]      ex_rd;
  logic            ex_is_load;
  logic            ex_illegal;

  modport master (
    output id_valid, id_cls, id_is_load, id_funct3, id_funct7b5, id_use_pc,
           id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm, id_pc,
           mem_wen, mem_rd, mem_data, wb_wen, wb_rd, wb_data, stall, flush,
    input  hazard_stall, ex_valid, ex_alu_op, ex_alu_a, ex_alu_b,
           ex_store_data, ex_rd, ex_is_load, ex_illegal
  );

  modport slave (
    input  id_valid, id_cls, id_is_load, id_funct3, id_funct7b5, id_use_pc,
           id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm, id_pc,
           mem_wen, mem_rd, mem_data, wb_wen, wb_rd, wb_data, stall, flush,
    output hazard_stall, ex_valid, ex_alu_op, ex_alu_a, ex_alu_b,
           ex_store_data, ex_rd, ex_is_load, ex_illegal
  );
endinterface

// File: rtl/ex_issue_stage.sv
// ex_issue_stage: RV32I decode-to-execute stage. Decodes class/funct3/funct7b5
// into the 4-bit ALU op, resolves operands with EX/MEM > MEM/WB forwarding and
// PC/immediate selection, detects load-use hazards and registers the result in
// the ID/EX register (flush > stall > bubble > capture).
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears every output register
//   bus : ex_issue_if.slave (ID inputs, forwarding, stall/flush, EX outputs)
module ex_issue_stage #(
  parameter int XLEN = 32
) (
  input logic      clk,
  input logic      rst,
  ex_issue_if.slave bus
);

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SRA = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SLT = 4'd8
  } alu_op_e;

  alu_op_e         op_d;
  logic            illegal_d;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic [XLEN-1:0] alu_a_d;
  logic [XLEN-1:0] alu_b_d;
  logic            is_store;
  logic            rs2_used;
  logic            hazard;

  logic            ex_valid_q;
  alu_op_e         ex_alu_op_q;
  logic [XLEN-1:0] ex_alu_a_q;
  logic [XLEN-1:0] ex_alu_b_q;
  logic [XLEN-1:0] ex_store_data_q;
  logic [4:0]      ex_rd_q;
  logic            ex_is_load_q;
  logic            ex_illegal_q;

  // ALU op decode; only classes 0/1 look at funct3
  always_comb begin
    op_d      = ALU_ADD;
    illegal_d = 1'b0;
    if (!bus.id_cls[1]) begin
      case (bus.id_funct3)
        3'b000: op_d = (bus.id_cls == 2'd0 && bus.id_funct7b5) ? ALU_SUB : ALU_ADD;
        3'b001: op_d = ALU_SLL;
        3'b010: op_d = ALU_SLT;
        3'b011: begin
          op_d      = ALU_ADD;
          illegal_d = 1'b1;
        end
        3'b100: op_d = ALU_XOR;
        3'b101: op_d = bus.id_funct7b5 ? ALU_SRA : ALU_SRL;
        3'b110: op_d = ALU_OR;
        3'b111: op_d = ALU_AND;
      endcase
    end
  end

  // Forwarding: EX/MEM wins over MEM/WB, x0 always reads the register file
  always_comb begin
    rs1_fwd = bus.id_rs1_data;
    if (bus.id_rs1 != '0) begin
      if (bus.mem_wen && bus.mem_rd == bus.id_rs1)
        rs1_fwd = bus.mem_data;
      else if (bus.wb_wen && bus.wb_rd == bus.id_rs1)
        rs1_fwd = bus.wb_data;
    end
  end

  always_comb begin
    rs2_fwd = bus.id_rs2_data;
    if (bus.id_rs2 != '0) begin
      if (bus.mem_wen && bus.mem_rd == bus.id_rs2)
        rs2_fwd = bus.mem_data;
      else if (bus.wb_wen && bus.wb_rd == bus.id_rs2)
        rs2_fwd = bus.wb_data;
    end
  end

  always_comb begin
    alu_a_d = rs1_fwd;
    if (bus.id_use_pc)
      alu_a_d = bus.id_pc;
    else if (bus.id_cls == 2'd3)
      alu_a_d = '0;
    alu_b_d = (bus.id_cls == 2'd0) ? rs2_fwd : bus.id_imm;
  end

  // rs2 only matters to the hazard check when it is actually read
  assign is_store = (bus.id_cls == 2'd2) && !bus.id_is_load && !bus.id_use_pc;
  assign rs2_used = (bus.id_cls == 2'd0) || is_store;
  assign hazard   = bus.id_valid && ex_valid_q && ex_is_load_q && (ex_rd_q != '0) &&
                    ((ex_rd_q == bus.id_rs1) || ((ex_rd_q == bus.id_rs2) && rs2_used));

  // Flush captures the payload fields too (they are dead once valid drops),
  // which lets flush and normal capture share one data-path enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q      <= 1'b0;
      ex_alu_op_q     <= ALU_ADD;
      ex_alu_a_q      <= '0;
      ex_alu_b_q      <= '0;
      ex_store_data_q <= '0;
      ex_rd_q         <= '0;
      ex_is_load_q    <= 1'b0;
      ex_illegal_q    <= 1'b0;
    end else begin
      if (bus.flush || (!bus.stall && !hazard)) begin
        ex_alu_op_q     <= op_d;
        ex_alu_a_q      <= alu_a_d;
        ex_alu_b_q      <= alu_b_d;
        ex_store_data_q <= rs2_fwd;
        ex_rd_q         <= bus.id_rd;
        ex_is_load_q    <= bus.id_is_load;
      end
      if (bus.flush) begin
        ex_valid_q   <= 1'b0;
        ex_illegal_q <= 1'b0;
      end else if (!bus.stall) begin
        if (hazard) begin
          ex_valid_q <= 1'b0;
        end else begin
          ex_valid_q   <= bus.id_valid;
          ex_illegal_q <= illegal_d;
        end
      end
    end
  end

  assign bus.hazard_stall  = hazard;
  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_alu_op     = ex_alu_op_q;
  assign bus.ex_alu_a      = ex_alu_a_q;
  assign bus.ex_alu_b      = ex_alu_b_q;
  assign bus.ex_store_data = ex_store_data_q;
  assign bus.ex_rd         = ex_rd_q;
  assign bus.ex_is_load    = ex_is_load_q;
  assign bus.ex_illegal    = ex_illegal_q;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Testbench for ex_issue_stage: table of single-cycle decode/forwarding vectors
// followed by hand-written load-use, stall/flush and reset sequences. Expected
// register contents are queued when stimulus is driven and popped after the
// capturing edge.
module tb_ex_issue_stage;

  logic clk;
  logic rst;

  ex_issue_if #(.XLEN(32)) bus ();

  ex_issue_stage #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [1:0]  cls;
    logic        ld;
    logic [2:0]  f3;
    logic        f7;
    logic        use_pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        mw;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        ww;
    logic [4:0]  wrd;
    logic [31:0] wd;
  } in_t;

  // mode 0: compare all fields; 1: valid only; 2: valid and illegal
  typedef struct packed {
    logic [1:0]  mode;
    logic        valid;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        ld;
    logic        ill;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[18];
  int   checks   = 0;
  int   failures = 0;

  function automatic in_t mk(input logic [1:0] cls, input logic [2:0] f3, input logic f7,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [31:0] rs1d, input logic [31:0] rs2d,
                             input logic [31:0] imm);
    in_t v;
    v       = '0;
    v.valid = 1'b1;
    v.cls   = cls;
    v.f3    = f3;
    v.f7    = f7;
    v.rs1   = rs1;
    v.rs2   = rs2;
    v.rd    = rd;
    v.rs1d  = rs1d;
    v.rs2d  = rs2d;
    v.imm   = imm;
    return v;
  endfunction

  function automatic exp_t ex(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] sd, input logic [4:0] rd, input logic ld,
                              input logic ill);
    exp_t e;
    e.mode  = 2'd0;
    e.valid = 1'b1;
    e.op    = op;
    e.a     = a;
    e.b     = b;
    e.sd    = sd;
    e.rd    = rd;
    e.ld    = ld;
    e.ill   = ill;
    return e;
  endfunction

  function automatic exp_t ex_bubble(input logic [1:0] mode);
    exp_t e;
    e      = '0;
    e.mode = mode;
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input in_t v);
    bus.id_valid    = v.valid;
    bus.id_cls      = v.cls;
    bus.id_is_load  = v.ld;
    bus.id_funct3   = v.f3;
    bus.id_funct7b5 = v.f7;
    bus.id_use_pc   = v.use_pc;
    bus.id_rs1      = v.rs1;
    bus.id_rs2      = v.rs2;
    bus.id_rd       = v.rd;
    bus.id_rs1_data = v.rs1d;
    bus.id_rs2_data = v.rs2d;
    bus.id_imm      = v.imm;
    bus.id_pc       = v.pc;
    bus.mem_wen     = v.mw;
    bus.mem_rd      = v.mrd;
    bus.mem_data    = v.md;
    bus.wb_wen      = v.ww;
    bus.wb_rd       = v.wrd;
    bus.wb_data     = v.wd;
  endtask

  task automatic step(input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard_empty actual=0 expected=1", nm);
    end else begin
      e = sb.pop_front();
      check({nm, ".valid"}, {31'd0, bus.ex_valid}, {31'd0, e.valid});
      if (e.mode == 2'd0) begin
        check({nm, ".op"}, {28'd0, bus.ex_alu_op}, {28'd0, e.op});
        check({nm, ".a"}, bus.ex_alu_a, e.a);
        check({nm, ".b"}, bus.ex_alu_b, e.b);
        check({nm, ".sd"}, bus.ex_store_data, e.sd);
        check({nm, ".rd"}, {27'd0, bus.ex_rd}, {27'd0, e.rd});
        check({nm, ".ld"}, {31'd0, bus.ex_is_load}, {31'd0, e.ld});
      end
      if (e.mode != 2'd1)
        check({nm, ".ill"}, {31'd0, bus.ex_illegal}, {31'd0, e.ill});
    end
  endtask

  // exp_haz < 0 skips the combinational hazard check
  task automatic issue(input string nm, input in_t v, input logic st, input logic fl,
                       input logic rs, input int exp_haz, input exp_t e);
    @(negedge clk);
    drive(v);
    bus.stall = st;
    bus.flush = fl;
    rst       = rs;
    #1;
    if (exp_haz >= 0)
      check({nm, ".haz"}, {31'd0, bus.hazard_stall}, exp_haz);
    sb.push_back(e);
    step(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t  v;
    in_t  ld4;
    exp_t zero;
    zero = '0;

    tbl[0]  = '{mk(2'd0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd10, 32'd5, 32'd7, 32'd0),
                ex(4'd0, 32'd5, 32'd7, 32'd7, 5'd10, 1'b0, 1'b0)};
    tbl[1]  = '{mk(2'd0, 3'd0, 1'b1, 5'd1, 5'd2, 5'd9, 32'd100, 32'd30, 32'd0),
                ex(4'd1, 32'd100, 32'd30, 32'd30, 5'd9, 1'b0, 1'b0)};
    tbl[2]  = '{mk(2'd1, 3'd0, 1'b1, 5'd3, 5'd4, 5'd11, 32'h20, 32'h99, 32'h10),
                ex(4'd0, 32'h20, 32'h10, 32'h99, 5'd11, 1'b0, 1'b0)};
    tbl[3]  = '{mk(2'd1, 3'd5, 1'b1, 5'd3, 5'd4, 5'd12, 32'h80, 32'h1, 32'd3),
                ex(4'd5, 32'h80, 32'd3, 32'h1, 5'd12, 1'b0, 1'b0)};
    tbl[4]  = '{mk(2'd0, 3'd5, 1'b0, 5'd3, 5'd4, 5'd13, 32'h80, 32'h2, 32'd0),
                ex(4'd6, 32'h80, 32'h2, 32'h2, 5'd13, 1'b0, 1'b0)};
    tbl[5]  = '{mk(2'd1, 3'd3, 1'b0, 5'd3, 5'd4, 5'd14, 32'h1, 32'h2, 32'h5),
                ex(4'd0, 32'h1, 32'h5, 32'h2, 5'd14, 1'b0, 1'b1)};
    tbl[6]  = '{mk(2'd0, 3'd1, 1'b0, 5'd1, 5'd2, 5'd15, 32'h1, 32'h4, 32'd0),
                ex(4'd7, 32'h1, 32'h4, 32'h4, 5'd15, 1'b0, 1'b0)};
    tbl[7]  = '{mk(2'd1, 3'd2, 1'b0, 5'd1, 5'd2, 5'd16, 32'h7, 32'h3, 32'hFFFF_FFFF),
                ex(4'd8, 32'h7, 32'hFFFF_FFFF, 32'h3, 5'd16, 1'b0, 1'b0)};
    tbl[8]  = '{mk(2'd0, 3'd4, 1'b0, 5'd1, 5'd2, 5'd17, 32'h0F, 32'hF0, 32'd0),
                ex(4'd4, 32'h0F, 32'hF0, 32'hF0, 5'd17, 1'b0, 1'b0)};
    tbl[9]  = '{mk(2'd0, 3'd6, 1'b0, 5'd1, 5'd2, 5'd18, 32'h0F, 32'hF0, 32'd0),
                ex(4'd3, 32'h0F, 32'hF0, 32'hF0, 5'd18, 1'b0, 1'b0)};
    tbl[10] = '{mk(2'd1, 3'd7, 1'b0, 5'd1, 5'd2, 5'd19, 32'h1234, 32'h5, 32'hFF),
                ex(4'd2, 32'h1234, 32'hFF, 32'h5, 5'd19, 1'b0, 1'b0)};
    // EX/MEM beats MEM/WB on the same register
    v = mk(2'd0, 3'd0, 1'b0, 5'd3, 5'd2, 5'd20, 32'h1111, 32'h22, 32'd0);
    v.mw = 1'b1; v.mrd = 5'd3; v.md = 32'hAAAA;
    v.ww = 1'b1; v.wrd = 5'd3; v.wd = 32'hBBBB;
    tbl[11] = '{v, ex(4'd0, 32'hAAAA, 32'h22, 32'h22, 5'd20, 1'b0, 1'b0)};
    // x0 never forwarded
    v = mk(2'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd21, 32'h0, 32'h55, 32'd0);
    v.mw = 1'b1; v.mrd = 5'd0; v.md = 32'hAAAA;
    v.ww = 1'b1; v.wrd = 5'd0; v.wd = 32'hBBBB;
    tbl[12] = '{v, ex(4'd0, 32'h0, 32'h55, 32'h55, 5'd21, 1'b0, 1'b0)};
    v = mk(2'd0, 3'd0, 1'b0, 5'd1, 5'd6, 5'd22, 32'h5, 32'h66, 32'd0);
    v.mw = 1'b1; v.mrd = 5'd7; v.md = 32'hAAAA;
    v.ww = 1'b1; v.wrd = 5'd6; v.wd = 32'h77;
    tbl[13] = '{v, ex(4'd0, 32'h5, 32'h77, 32'h77, 5'd22, 1'b0, 1'b0)};
    // AUIPC with funct3=011 must not be illegal
    v = mk(2'd2, 3'd3, 1'b0, 5'd1, 5'd2, 5'd23, 32'h5, 32'h6, 32'h2000);
    v.use_pc = 1'b1; v.pc = 32'h1000;
    tbl[14] = '{v, ex(4'd0, 32'h1000, 32'h2000, 32'h6, 5'd23, 1'b0, 1'b0)};
    tbl[15] = '{mk(2'd3, 3'd5, 1'b1, 5'd1, 5'd2, 5'd24, 32'h999, 32'h6, 32'hABCDE000),
                ex(4'd0, 32'h0, 32'hABCDE000, 32'h6, 5'd24, 1'b0, 1'b0)};
    v = mk(2'd2, 3'd2, 1'b0, 5'd2, 5'd8, 5'd0, 32'h40, 32'h44, 32'd4);
    v.mw = 1'b1; v.mrd = 5'd8; v.md = 32'h88;
    tbl[16] = '{v, ex(4'd0, 32'h40, 32'd4, 32'h88, 5'd0, 1'b0, 1'b0)};
    ld4 = mk(2'd2, 3'd2, 1'b0, 5'd2, 5'd0, 5'd4, 32'h100, 32'h0, 32'd8);
    ld4.ld = 1'b1;
    tbl[17] = '{ld4, ex(4'd0, 32'h100, 32'd8, 32'h0, 5'd4, 1'b1, 1'b0)};

    rst = 1'b1;
    drive(tbl[0].i);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    issue("reset0", tbl[0].i, 1'b0, 1'b0, 1'b1, -1, zero);
    issue("reset1", tbl[0].i, 1'b0, 1'b0, 1'b1, 0, zero);

    for (int unsigned k = 0; k < 18; k++)
      issue($sformatf("vec%0d", k), tbl[k].i, 1'b0, 1'b0, 1'b0, 0, tbl[k].e);

    // load x4 in EX; I-type only reads rs1, so rs2=x4 is no hazard
    issue("lu_itype", mk(2'd1, 3'd0, 1'b0, 5'd1, 5'd4, 5'd6, 32'h10, 32'h20, 32'd3),
          1'b0, 1'b0, 1'b0, 0, ex(4'd0, 32'h10, 32'd3, 32'h20, 5'd6, 1'b0, 1'b0));
    issue("lu_load", ld4, 1'b0, 1'b0, 1'b0, 0, tbl[17].e);
    v = mk(2'd0, 3'd0, 1'b0, 5'd1, 5'd4, 5'd5, 32'h10, 32'h0, 32'd0);
    issue("lu_bubble", v, 1'b0, 1'b0, 1'b0, 1, ex_bubble(2'd1));
    v.ww = 1'b1; v.wrd = 5'd4; v.wd = 32'd9;
    issue("lu_fwd", v, 1'b0, 1'b0, 1'b0, 0, ex(4'd0, 32'h10, 32'd9, 32'd9, 5'd5, 1'b0, 1'b0));
    issue("lu_load2", ld4, 1'b0, 1'b0, 1'b0, 0, tbl[17].e);
    v = mk(2'd2, 3'd2, 1'b0, 5'd1, 5'd4, 5'd0, 32'h10, 32'h0, 32'd4);
    issue("lu_store", v, 1'b0, 1'b0, 1'b0, 1, ex_bubble(2'd1));
    v.ww = 1'b1; v.wrd = 5'd4; v.wd = 32'd9;
    issue("lu_store_fwd", v, 1'b0, 1'b0, 1'b0, 0,
          ex(4'd0, 32'h10, 32'd4, 32'd9, 5'd0, 1'b0, 1'b0));
    v = ld4; v.rd = 5'd0;
    issue("lu_load_x0", v, 1'b0, 1'b0, 1'b0, 0, ex(4'd0, 32'h100, 32'd8, 32'h0, 5'd0, 1'b1, 1'b0));
    issue("lu_x0_dep", mk(2'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd5, 32'h3, 32'h4, 32'd0),
          1'b0, 1'b0, 1'b0, 0, ex(4'd0, 32'h3, 32'h4, 32'h4, 5'd5, 1'b0, 1'b0));
    issue("lu_load3", ld4, 1'b0, 1'b0, 1'b0, 0, tbl[17].e);
    issue("lu_rs1", mk(2'd1, 3'd0, 1'b0, 5'd4, 5'd0, 5'd7, 32'h1, 32'h0, 32'd2),
          1'b0, 1'b0, 1'b0, 1, ex_bubble(2'd1));

    // stall holds everything, flush beats stall and clears illegal
    issue("st_cap", tbl[1].i, 1'b0, 1'b0, 1'b0, 0, tbl[1].e);
    for (int unsigned k = 0; k < 3; k++)
      issue($sformatf("st_hold%0d", k), tbl[0].i, 1'b1, 1'b0, 1'b0, 0, tbl[1].e);
    issue("st_flush", tbl[5].i, 1'b1, 1'b1, 1'b0, 0, ex_bubble(2'd2));
    issue("ill_cap", tbl[5].i, 1'b0, 1'b0, 1'b0, 0, tbl[5].e);
    issue("flush_ill", tbl[5].i, 1'b0, 1'b1, 1'b0, 0, ex_bubble(2'd2));

    // reset mid-stream, and reset overriding stall
    issue("rs_cap", tbl[0].i, 1'b0, 1'b0, 1'b0, 0, tbl[0].e);
    issue("rs_mid", tbl[1].i, 1'b0, 1'b0, 1'b1, 0, zero);
    issue("rs_cap2", tbl[8].i, 1'b0, 1'b0, 1'b0, 0, tbl[8].e);
    issue("rs_stall", tbl[1].i, 1'b1, 1'b0, 1'b1, 0, zero);
    issue("rs_after", tbl[2].i, 1'b0, 1'b0, 1'b0, 0, tbl[2].e);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_issue_stage.md
# ex_issue_stage

Decode-to-execute pipeline stage of the RV32I core that feeds the ALU. It translates decoded instruction fields into the ALU's 4-bit op code and resolves both operands, including EX/MEM and MEM/WB forwarding and immediate/PC selection. It detects load-use hazards and registers everything into the ID/EX pipeline register with stall, flush and bubble insertion. The ALU consumes `ex_alu_op`, `ex_alu_a` and `ex_alu_b` directly one cycle after issue.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  decode slot holds a real instruction.
- `id_cls`  in  2  instruction class: 0 = R-type ALU, 1 = I-type ALU, 2 = address/PC add (load, store, AUIPC, JAL, JALR), 3 = LUI.
- `id_is_load`  in  1  instruction is a load.
- `id_funct3`  in  3  instruction funct3.
- `id_funct7b5`  in  1  instruction bit 30.
- `id_use_pc`  in  1  operand A is the PC rather than rs1.
- `id_rs1`, `id_rs2`, `id_rd`  in  5 each  register addresses.
- `id_rs1_data`, `id_rs2_data`  in  32 each  register-file read data.
- `id_imm`  in  32  sign-extended immediate.
- `id_pc`  in  32  instruction PC.
- `mem_wen`, `mem_rd`, `mem_data`  in  1/5/32  EX/MEM writeback forwarding source.
- `wb_wen`, `wb_rd`, `wb_data`  in  1/5/32  MEM/WB writeback forwarding source.
- `stall`  in  1  downstream stall; hold the register.
- `flush`  in  1  kill the instruction being captured (branch redirect).
- `hazard_stall`  out  1  combinational load-use stall request to fetch/decode.
- `ex_valid`  out  1  registered valid.
- `ex_alu_op`  out  4  ALU op code.
- `ex_alu_a`, `ex_alu_b`  out  32 each  ALU operands.
- `ex_store_data`  out  32  forwarded rs2 value, used for stores.
- `ex_rd`  out  5  destination register.
- `ex_is_load`  out  1  registered load flag.
- `ex_illegal`  out  1  unsupported encoding.

## Operation
- ALU op codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SRA=5, SRL=6, SLL=7, SLT=8.
- Decode for classes 0 and 1, by funct3:
  - 000: SUB only if class 0 and `id_funct7b5`=1; otherwise ADD.
  - 001: SLL.
  - 010: SLT.
  - 011 (SLTU): not supported; op=ADD, `ex_illegal`=1.
  - 100: XOR.
  - 101: SRA if `id_funct7b5`=1, else SRL. This rule applies to class 1 as well.
  - 110: OR.
  - 111: AND.
- Classes 2 and 3 always decode to ADD.
- Forwarding, applied independently to rs1 and rs2:
  - Use `mem_data` if `mem_wen` and `mem_rd`==rs and rs!=0.
  - Else use `wb_data` if `wb_wen` and `wb_rd`==rs and rs!=0.
  - Else use the register-file data.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
- Operand A:
  - `id_pc` if `id_use_pc`.
  - 0 if class 3.
  - Otherwise forwarded rs1.
- Operand B: forwarded rs2 for class 0; `id_imm` for all other classes.
- `ex_store_data` is always forwarded rs2.
- `hazard_stall` = `id_valid` & `ex_valid` & `ex_is_load` & `ex_rd`!=0 & (`ex_rd`==`id_rs1` | (`ex_rd`==`id_rs2` & class 0 or store)).
  - Store is indicated by class 2 with `id_is_load`=0 and `id_use_pc`=0.

## Timing
- Reset: every output register is 0 (`ex_valid`=0, `ex_alu_op`=ADD, operands 0, `ex_illegal`=0). Reset overrides stall and flush.
- Latency: 1 cycle from ID inputs to the registered EX outputs.
- Per-edge register update, highest priority first:
  - `flush`=1: `ex_valid`<=0 and `ex_illegal`<=0; other fields update freely (don't-care).
  - Else `stall`=1: every register holds, including `ex_valid`.
  - Else `hazard_stall`=1: bubble; `ex_valid`<=0. The upstream stage holds the ID inputs.
  - Else: capture all fields; `ex_valid`<=`id_valid`.
- Flush and stall together: flush wins.
- `hazard_stall` is purely combinational from current ID inputs and the registered EX state.
- After a bubble, `ex_valid`=0, so `hazard_stall` deasserts. The next cycle then forwards the load result from MEM/WB.
- `hazard_stall` is asserted whenever its equation holds, independent of `stall`; fetch/decode already holds for either request.

## Test plan
- **ADD decode:** R-type funct3=000, funct7b5=0, rs1=5, rs2=7 (no forwarding) -> next cycle `ex_alu_op`=0, a=5, b=7, `ex_valid`=1.
- **SRAI decode:** I-type funct3=101, funct7b5=1, imm=3 -> `ex_alu_op`=5, b=3. Same with funct3=011 -> `ex_illegal`=1, op=0.
- **Forwarding priority:** rs1=x3; `mem_wen` with rd=3, data=0xAAAA; `wb_wen` with rd=3, data=0xBBBB -> a=0xAAAA. Repeat with rs1=x0 and both sources rd=0 -> a equals the `id_rs1_data` value of 0.
- **Load-use:** load to x4 in EX, ID holds ADD using rs2=x4 -> `hazard_stall`=1 and next `ex_valid`=0. Following cycle with `wb_rd`=4, data=9 -> b=9, `ex_valid`=1.
- **Stall and flush:** `stall`=1 for 3 cycles -> all outputs hold. `stall`=`flush`=1 -> `ex_valid`=0 next cycle.
- **Reset mid-stream:** `rst` asserted while `ex_valid`=1 -> next cycle all outputs 0. `rst` asserted with `stall`=1 -> still 0.
